bru_resolve: RTL and testbench
==============================

# bru_resolve

Parametrised branch resolution stage for the pipelined core, placed at the EX boundary. It accepts one branch or jump per handshake and evaluates the condition for any XLEN. It computes the taken and not-taken targets and compares them with the fetch-stage prediction. On a mispredict it holds a registered redirect request until the front end acknowledges it.

## Interface
- XLEN, 32, operand/PC width (≥8).
- CNT_W, 32, perf-counter width (only with macro).

- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock; reset is asynchronous and active-low
- valid_i  in  1  instruction present
- ready_o  out  1  block can accept
- rs1_data_i, rs2_data_i  in  XLEN  operands
- pc_i, imm_i  in  XLEN  instruction PC, sign-extended immediate
- is_br_i, is_uncbr_i, is_jalr_i  in  1  conditional branch / JAL / JALR (one-hot or none)
- funct3_i  in  3  branch condition
- pred_taken_i  in  1  fetch prediction
- pred_target_i  in  XLEN  predicted target
- flush_i  in  1  synchronous kill from younger-stage exception
- valid_o  out  1  result valid
- ready_i  in  1  consumer accepts
- taken_o  out  1  resolved direction
- target_o  out  XLEN  resolved next PC
- link_o  out  XLEN  pc_i+4 for rd write
- mispredict_o  out  1  direction or target wrong
- redirect_valid_o  out  1  redirect request to fetch
- redirect_pc_o  out  XLEN  redirect address
- redirect_ack_i  in  1  fetch accepted redirect
- br_cnt_o, mispred_cnt_o  out  CNT_W  perf counters (macro only)

## Operation
- Compare: sub = rs1 + ~rs2 + 1 at XLEN+1 bits. eq = (sub==0). ltu = ~carry. lt = sub[MSB] ^ overflow.
- funct3: 000 eq; 001 !eq; 100 lt; 101 !lt; 110 ltu; 111 !ltu. Other values give not-taken.
- taken = is_uncbr | is_jalr | (is_br & cond).
- target: br/JAL = pc+imm; JALR = (rs1+imm) with bit0 cleared. Not taken: pc+4. All sums are mod 2^XLEN.
- mispredict = (taken != pred_taken) | (taken & target != pred_target). Non-branch instructions never mispredict.
- FSM states:
  - RUN: ready_o = !valid_o | ready_i.
  - REDIR: ready_o = 0, redirect_valid_o = 1.
- RUN→REDIR when a mispredicting instruction is accepted.
- REDIR→RUN on redirect_ack_i. REDIR→RUN on flush_i.
- redirect_pc_o is registered with the result. It holds stable in REDIR.
- flush_i has top priority. It clears valid_o and redirect_valid_o, discards the input that cycle, and enters RUN.

## Timing
- Reset values: all outputs 0, FSM RUN, counters 0. ready_o = 1 after reset.
- Latency: accept at edge N gives valid_o and redirect_valid_o high from N+1.
- valid_o holds with stable data until valid_o & ready_i.
- Output and redirect handshakes are independent. The result can retire while REDIR is still waiting for ack.
- A new accept is allowed in the same cycle the previous result retires. That is full throughput in RUN.
- ack and flush in the same cycle: flush wins, and the result is RUN.
- Reset mid-REDIR: asynchronous return to RUN with all outputs 0.

## Configuration
- BRU_RESOLVE_PERF_EN defined:
  - br_cnt_o increments on each retiring output handshake.
  - mispred_cnt_o increments when that handshake also carries mispredict_o.
  - Both saturate at all-ones.
  - Flushed results are not counted.
- Macro undefined: both counter ports tie to 0 and no counter flops exist.

## Structure
- Shared package bru_pkg holds:
  - funct3 localparams (BEQ, BNE, BLT, BGE, BLTU, BGEU).
  - fsm_e enum {RUN, REDIR}.
  - br_res_t struct {taken, target, link, mispredict}.
- One sub-module, bru_cmp, is combinational and parametrised by XLEN. It outputs eq/lt/ltu.

## Test plan
- XLEN=32, BLT rs1=0xFFFFFFFF rs2=1, pred_taken=1, pred_target=pc+imm → taken_o=1, mispredict_o=0, valid_o one cycle after accept.
- BLTU with the same operands, pred_taken=1 → taken_o=0, target_o=pc+4, mispredict_o=1. redirect_pc_o=pc+4 holds and ready_o=0 until redirect_ack_i.
- JALR rs1=0x1001 imm=2 → target_o=0x1002, link_o=pc+4. pred_target=0x1003 → mispredict.
- ready_i held low 3 cycles with valid_i=1 → output stable, ready_o=0, no second accept. Back-to-back accepts once ready_i=1.
- flush_i in REDIR together with redirect_ack_i and valid_i → valid_o=0, redirect_valid_o=0, RUN, input dropped, counters unchanged.
- XLEN=8, PERF_EN, CNT_W=2: 5 retiring mispredicts → mispred_cnt_o saturates at 3. pc=0xFC BEQ not taken → target 0x00.

Source files
------------

// File: rtl/bru_resolve_pkg.sv
// -----------------------------------------------------------------------------
// bru_pkg - shared definitions for the branch resolution stage.
//   * funct3 encodings of the conditional branches
//   * fsm_e        : resolution FSM states (RUN / REDIR)
//   * br_res_t     : resolved result record. Address fields are sized for the
//                    widest supported XLEN (BR_XLEN_MAX); narrower instances
//                    zero-extend into them and use the low XLEN bits.
// -----------------------------------------------------------------------------
package bru_pkg;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    // Largest XLEN the result record can carry.
    localparam int BR_XLEN_MAX = 64;

    typedef enum logic {
        RUN   = 1'b0,
        REDIR = 1'b1
    } fsm_e;

    typedef struct packed {
        logic                   taken;
        logic [BR_XLEN_MAX-1:0] target;
        logic [BR_XLEN_MAX-1:0] link;
        logic                   mispredict;
    } br_res_t;

endpackage

// File: rtl/bru_resolve_if.sv
// -----------------------------------------------------------------------------
// bru_resolve_if - bundle of every non-clock/reset signal of bru_resolve.
//   Parameters: XLEN (operand/PC width), CNT_W (perf counter width).
//   master : upstream/front-end side (drives *_i, samples *_o)
//   slave  : bru_resolve side
//   Input side : valid_i/ready_o, rs1_data_i, rs2_data_i, pc_i, imm_i,
//                is_br_i, is_uncbr_i, is_jalr_i, funct3_i, pred_taken_i,
//                pred_target_i, flush_i
//   Output side: valid_o/ready_i, taken_o, target_o, link_o, mispredict_o
//   Redirect   : redirect_valid_o, redirect_pc_o, redirect_ack_i
//   Perf       : br_cnt_o, mispred_cnt_o
// -----------------------------------------------------------------------------
interface bru_resolve_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) ();
    logic             valid_i;
    logic             ready_o;
    logic [XLEN-1:0]  rs1_data_i;
    logic [XLEN-1:0]  rs2_data_i;
    logic [XLEN-1:0]  pc_i;
    logic [XLEN-1:0]  imm_i;
    logic             is_br_i;
    logic             is_uncbr_i;
    logic             is_jalr_i;
    logic [2:0]       funct3_i;
    logic             pred_taken_i;
    logic [XLEN-1:0]  pred_target_i;
    logic             flush_i;
    logic             valid_o;
    logic             ready_i;
    logic             taken_o;
    logic [XLEN-1:0]  target_o;
    logic [XLEN-1:0]  link_o;
    logic             mispredict_o;
    logic             redirect_valid_o;
    logic [XLEN-1:0]  redirect_pc_o;
    logic             redirect_ack_i;
    logic [CNT_W-1:0] br_cnt_o;
    logic [CNT_W-1:0] mispred_cnt_o;

    modport master (
        output valid_i, rs1_data_i, rs2_data_i, pc_i, imm_i,
               is_br_i, is_uncbr_i, is_jalr_i, funct3_i,
               pred_taken_i, pred_target_i, flush_i, ready_i, redirect_ack_i,
        input  ready_o, valid_o, taken_o, target_o, link_o, mispredict_o,
               redirect_valid_o, redirect_pc_o, br_cnt_o, mispred_cnt_o
    );

    modport slave (
        input  valid_i, rs1_data_i, rs2_data_i, pc_i, imm_i,
               is_br_i, is_uncbr_i, is_jalr_i, funct3_i,
               pred_taken_i, pred_target_i, flush_i, ready_i, redirect_ack_i,
        output ready_o, valid_o, taken_o, target_o, link_o, mispredict_o,
               redirect_valid_o, redirect_pc_o, br_cnt_o, mispred_cnt_o
    );
endinterface

// File: rtl/bru_resolve_cmp.sv
// -----------------------------------------------------------------------------
// bru_cmp - combinational branch comparator, parametrised by XLEN.
//   i_a, i_b : operands (rs1, rs2)
//   o_eq     : i_a == i_b
//   o_lt     : signed   i_a < i_b
//   o_ltu    : unsigned i_a < i_b
// One XLEN+1 bit subtract (a + ~b + 1) provides all three flags.
// -----------------------------------------------------------------------------
module bru_cmp #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_eq,
    output logic            o_lt,
    output logic            o_ltu
);
    logic [XLEN:0] w_sub;
    logic          w_ovf;

    assign w_sub = {1'b0, i_a} + {1'b0, ~i_b} + (XLEN+1)'(1);

    // Signed overflow: operand signs differ and the result sign differs from a.
    assign w_ovf = (i_a[XLEN-1] ^ i_b[XLEN-1]) & (w_sub[XLEN-1] ^ i_a[XLEN-1]);

    assign o_eq  = (w_sub[XLEN-1:0] == '0);
    assign o_ltu = ~w_sub[XLEN];          // no carry out means a borrow occurred
    assign o_lt  = w_sub[XLEN-1] ^ w_ovf;
endmodule

// File: rtl/bru_resolve.sv
// -----------------------------------------------------------------------------
// bru_resolve - branch resolution stage at the EX boundary.
//   Parameters: XLEN (8..64), CNT_W (perf counter width)
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   bus    : bru_resolve_if.slave - instruction input handshake, result output
//            handshake, redirect request/ack, perf counters
// Accepts one branch/jump per handshake, resolves direction and target,
// compares with the fetch prediction and, on a mispredict, holds a redirect
// request (REDIR state) until the front end acknowledges it. flush_i kills
// the pending result and redirect and drops the input of that cycle.
// Optional feature: define BRU_RESOLVE_PERF_EN for saturating retire and
// mispredict counters; otherwise the counter outputs are constant zero.
// -----------------------------------------------------------------------------
module bru_resolve
    import bru_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    bru_resolve_if.slave  bus
);
    logic            w_eq, w_lt, w_ltu, w_cond, w_taken, w_is_cf;
    logic            w_ready, w_accept, w_retire, w_redirect_valid;
    logic [XLEN-1:0] w_seq_pc, w_br_target, w_jalr_sum, w_target;
    br_res_t         w_res, r_res;
    fsm_e            r_state, w_state_next;
    logic            r_valid;
    logic [XLEN-1:0] r_redirect_pc;
    logic            w_unused_bits;

    bru_cmp #(.XLEN(XLEN)) u_cmp (
        .i_a   (bus.rs1_data_i),
        .i_b   (bus.rs2_data_i),
        .o_eq  (w_eq),
        .o_lt  (w_lt),
        .o_ltu (w_ltu)
    );

    always_comb begin
        w_cond = 1'b0;
        case (bus.funct3_i)
            BEQ:     w_cond = w_eq;
            BNE:     w_cond = ~w_eq;
            BLT:     w_cond = w_lt;
            BGE:     w_cond = ~w_lt;
            BLTU:    w_cond = w_ltu;
            BGEU:    w_cond = ~w_ltu;
            default: w_cond = 1'b0;
        endcase
    end

    assign w_is_cf     = bus.is_br_i | bus.is_uncbr_i | bus.is_jalr_i;
    assign w_taken     = bus.is_uncbr_i | bus.is_jalr_i | (bus.is_br_i & w_cond);
    assign w_seq_pc    = bus.pc_i + XLEN'(4);
    assign w_br_target = bus.pc_i + bus.imm_i;
    assign w_jalr_sum  = bus.rs1_data_i + bus.imm_i;

    always_comb begin
        w_target = w_seq_pc;
        if (w_taken) begin
            if (bus.is_jalr_i) w_target = {w_jalr_sum[XLEN-1:1], 1'b0};
            else               w_target = w_br_target;
        end
    end

    always_comb begin
        w_res            = '0;
        w_res.taken      = w_taken;
        w_res.target     = BR_XLEN_MAX'(w_target);
        w_res.link       = BR_XLEN_MAX'(w_seq_pc);
        // Non control-flow instructions never mispredict.
        w_res.mispredict = w_is_cf &
                           ((w_taken != bus.pred_taken_i) |
                            (w_taken & (w_target != bus.pred_target_i)));
    end

    // Handshakes. The output slot frees in the same cycle it retires, giving
    // full throughput in RUN; REDIR blocks new work until the redirect is taken.
    assign w_ready  = (r_state == RUN) & (~r_valid | bus.ready_i);
    assign w_accept = bus.valid_i & w_ready & ~bus.flush_i;
    assign w_retire = r_valid & bus.ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= RUN;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next     = r_state;
        w_redirect_valid = 1'b0;
        case (r_state)
            RUN: begin
                if (w_accept && w_res.mispredict) w_state_next = REDIR;
            end
            REDIR: begin
                w_redirect_valid = 1'b1;
                if (bus.redirect_ack_i) w_state_next = RUN;
            end
            default: w_state_next = RUN;
        endcase
        if (bus.flush_i) w_state_next = RUN;   // flush beats ack and accept
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid       <= 1'b0;
            r_res         <= '0;
            r_redirect_pc <= '0;
        end else if (bus.flush_i) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_res   <= w_res;
            if (w_res.mispredict) r_redirect_pc <= w_target;
        end else if (w_retire) begin
            r_valid <= 1'b0;
        end
    end

`ifdef BRU_RESOLVE_PERF_EN
    logic [CNT_W-1:0] r_br_cnt, r_mispred_cnt;

    // Count retiring results only; a flush in the same cycle discards it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_br_cnt      <= '0;
            r_mispred_cnt <= '0;
        end else if (w_retire && !bus.flush_i) begin
            if (r_br_cnt != '1) r_br_cnt <= r_br_cnt + CNT_W'(1);
            if (r_res.mispredict && (r_mispred_cnt != '1))
                r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
        end
    end

    assign bus.br_cnt_o      = r_br_cnt;
    assign bus.mispred_cnt_o = r_mispred_cnt;
`else
    assign bus.br_cnt_o      = {CNT_W{1'b0}};
    assign bus.mispred_cnt_o = {CNT_W{1'b0}};
`endif

    assign bus.ready_o          = w_ready;
    assign bus.valid_o          = r_valid;
    assign bus.taken_o          = r_res.taken;
    assign bus.target_o         = r_res.target[XLEN-1:0];
    assign bus.link_o           = r_res.link[XLEN-1:0];
    assign bus.mispredict_o     = r_res.mispredict;
    assign bus.redirect_valid_o = w_redirect_valid;
    assign bus.redirect_pc_o    = r_redirect_pc;

    // Record bits above XLEN are always zero and have no consumer.
    assign w_unused_bits = ^{r_res.target, r_res.link};
endmodule

// File: tb/tb_bru_resolve.sv
// -----------------------------------------------------------------------------
// tb_bru_resolve - self-checking bench for bru_resolve.
// Directed vector table, hand-written multi-cycle sequences (stall, flush in
// REDIR, async reset in REDIR, XLEN=8 wrap and counter saturation) and a
// randomized phase checked against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_bru_resolve;

`ifdef BRU_RESOLVE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [2:0] F_BEQ = 3'b000, F_BNE = 3'b001, F_BLT = 3'b100,
                           F_BGE = 3'b101, F_BLTU = 3'b110, F_BGEU = 3'b111;

    typedef struct {
        logic        br, unc, jalr;
        logic [2:0]  f3;
        logic [31:0] rs1, rs2, pc, imm;
        logic        pt;
        logic [31:0] ptgt;
    } ins_t;

    typedef struct {
        logic        taken;
        logic [31:0] target, link;
        logic        mis;
    } res_t;

    typedef struct {
        ins_t in;
        res_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    bru_resolve_if #(.XLEN(32), .CNT_W(32)) bus ();
    bru_resolve_if #(.XLEN(8),  .CNT_W(2))  bus8 ();

    bru_resolve #(.XLEN(32), .CNT_W(32)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus.slave));
    bru_resolve #(.XLEN(8),  .CNT_W(2))  dut8 (.clk_i(clk), .rst_ni(rst_n), .bus(bus8.slave));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: direct evaluation of the branch rules with plain arithmetic.
    function automatic res_t ref_model(input ins_t x);
        res_t r;
        logic cond;
        case (x.f3)
            F_BEQ:   cond = (x.rs1 == x.rs2);
            F_BNE:   cond = (x.rs1 != x.rs2);
            F_BLT:   cond = ($signed(x.rs1) <  $signed(x.rs2));
            F_BGE:   cond = ($signed(x.rs1) >= $signed(x.rs2));
            F_BLTU:  cond = (x.rs1 <  x.rs2);
            F_BGEU:  cond = (x.rs1 >= x.rs2);
            default: cond = 1'b0;
        endcase
        r.taken = x.unc | x.jalr | (x.br & cond);
        r.link  = x.pc + 32'd4;
        if (!r.taken)   r.target = x.pc + 32'd4;
        else if (x.jalr) r.target = (x.rs1 + x.imm) & 32'hFFFF_FFFE;
        else            r.target = x.pc + x.imm;
        r.mis = (x.br | x.unc | x.jalr) &&
                ((r.taken != x.pt) || (r.taken && (r.target != x.ptgt)));
        return r;
    endfunction

    function automatic ins_t mk(input logic br, input logic unc, input logic jalr,
                                input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] rs2,
                                input logic [31:0] pc, input logic [31:0] imm,
                                input logic pt, input logic [31:0] ptgt);
        ins_t x;
        x.br = br; x.unc = unc; x.jalr = jalr; x.f3 = f3; x.rs1 = rs1; x.rs2 = rs2;
        x.pc = pc; x.imm = imm; x.pt = pt; x.ptgt = ptgt;
        return x;
    endfunction

    task automatic drive(input ins_t x);
        bus.is_br_i = x.br; bus.is_uncbr_i = x.unc; bus.is_jalr_i = x.jalr;
        bus.funct3_i = x.f3; bus.rs1_data_i = x.rs1; bus.rs2_data_i = x.rs2;
        bus.pc_i = x.pc; bus.imm_i = x.imm; bus.pred_taken_i = x.pt; bus.pred_target_i = x.ptgt;
    endtask

    task automatic chk_res(input string tag, input res_t e);
        chk({tag, "_valid"},  bus.valid_o, 1);
        chk({tag, "_taken"},  bus.taken_o, e.taken);
        chk({tag, "_target"}, bus.target_o, e.target);
        chk({tag, "_link"},   bus.link_o, e.link);
        chk({tag, "_mis"},    bus.mispredict_o, e.mis);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("v%0d", idx);
        @(posedge clk); #1;
        drive(v.in);
        bus.valid_i = 1'b1; bus.ready_i = 1'b1; bus.redirect_ack_i = 1'b0; bus.flush_i = 1'b0;
        @(negedge clk);
        chk({tag, "_ready_in"}, bus.ready_o, 1);
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        @(negedge clk);
        chk_res(tag, v.exp);
        chk({tag, "_redir_v"}, bus.redirect_valid_o, v.exp.mis);
        $display("vec %0d: taken=%0b target=0x%08h link=0x%08h mis=%0b",
                 idx, bus.taken_o, bus.target_o, bus.link_o, bus.mispredict_o);
        if (v.exp.mis) begin
            // Result retires while the redirect keeps waiting for its ack.
            for (int c = 0; c < 2; c++) begin
                @(posedge clk); #1;
                @(negedge clk);
                chk({tag, "_hold_pc"},    bus.redirect_pc_o, v.exp.target);
                chk({tag, "_hold_rv"},    bus.redirect_valid_o, 1);
                chk({tag, "_hold_ready"}, bus.ready_o, 0);
                chk({tag, "_retired"},    bus.valid_o, 0);
            end
            @(posedge clk); #1;
            bus.redirect_ack_i = 1'b1;
            @(posedge clk); #1;
            bus.redirect_ack_i = 1'b0;
            @(negedge clk);
            chk({tag, "_ack_rv"},    bus.redirect_valid_o, 0);
            chk({tag, "_ack_ready"}, bus.ready_o, 1);
        end
    endtask

    task automatic idle_inputs();
        drive(mk(0, 0, 0, 3'b0, 0, 0, 0, 0, 0, 0));
        bus.valid_i = 1'b0; bus.ready_i = 1'b0; bus.flush_i = 1'b0; bus.redirect_ack_i = 1'b0;
        bus8.valid_i = 1'b0; bus8.ready_i = 1'b0; bus8.flush_i = 1'b0; bus8.redirect_ack_i = 1'b0;
        bus8.is_br_i = 1'b0; bus8.is_uncbr_i = 1'b0; bus8.is_jalr_i = 1'b0; bus8.funct3_i = 3'b0;
        bus8.rs1_data_i = '0; bus8.rs2_data_i = '0; bus8.pc_i = '0; bus8.imm_i = '0;
        bus8.pred_taken_i = 1'b0; bus8.pred_target_i = '0;
    endtask

    vec_t vecs[11];
    ins_t xa, xb, xc;
    res_t e;

    // random-phase model state
    logic        m_valid, m_redir, m_ready;
    res_t        m_res;
    logic [31:0] m_rpc;
    longint      m_br, m_mis;
    logic        r_vld, r_rdy, r_ack, r_fl;
    ins_t        rx;

    initial begin
        idle_inputs();

        // ---------------- reset values ----------------
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid",   bus.valid_o, 0);
        chk("rst_ready",   bus.ready_o, 1);
        chk("rst_rv",      bus.redirect_valid_o, 0);
        chk("rst_taken",   bus.taken_o, 0);
        chk("rst_target",  bus.target_o, 0);
        chk("rst_link",    bus.link_o, 0);
        chk("rst_mis",     bus.mispredict_o, 0);
        chk("rst_rpc",     bus.redirect_pc_o, 0);
        chk("rst_brcnt",   bus.br_cnt_o, 0);
        chk("rst_miscnt",  bus.mispred_cnt_o, 0);
        chk("rst8_ready",  bus8.ready_o, 1);
        chk("rst8_miscnt", bus8.mispred_cnt_o, 0);
        rst_n = 1'b1;

        // ---------------- vector table (expected values hand-derived) -----
        vecs[0]  = '{mk(1,0,0,F_BLT, 32'hFFFF_FFFF, 1, 32'h100, 32'h20, 1, 32'h120), '{1, 32'h120, 32'h104, 0}};
        vecs[1]  = '{mk(1,0,0,F_BLTU,32'hFFFF_FFFF, 1, 32'h100, 32'h20, 1, 32'h120), '{0, 32'h104, 32'h104, 1}};
        vecs[2]  = '{mk(0,0,1,F_BEQ, 32'h1001, 0, 32'h100, 32'h2, 1, 32'h1003),       '{1, 32'h1002, 32'h104, 1}};
        vecs[3]  = '{mk(1,0,0,F_BEQ, 5, 5, 32'h100, 32'h20, 0, 0),                    '{1, 32'h120, 32'h104, 1}};
        vecs[4]  = '{mk(1,0,0,F_BNE, 5, 5, 32'h100, 32'h20, 0, 0),                    '{0, 32'h104, 32'h104, 0}};
        vecs[5]  = '{mk(1,0,0,F_BGE, 32'h8000_0000, 32'h7FFF_FFFF, 32'h100, 32'h20, 0, 0),       '{0, 32'h104, 32'h104, 0}};
        vecs[6]  = '{mk(1,0,0,F_BGEU,32'h8000_0000, 32'h7FFF_FFFF, 32'h100, 32'h20, 1, 32'h120), '{1, 32'h120, 32'h104, 0}};
        vecs[7]  = '{mk(1,0,0,3'b010, 7, 7, 32'h100, 32'h20, 0, 0),                   '{0, 32'h104, 32'h104, 0}};
        vecs[8]  = '{mk(0,1,0,F_BEQ, 0, 0, 32'h100, 32'hFFFF_FFF0, 1, 32'hF0),        '{1, 32'hF0, 32'h104, 0}};
        vecs[9]  = '{mk(0,0,0,F_BEQ, 3, 3, 32'h100, 32'h20, 1, 32'h120),              '{0, 32'h104, 32'h104, 0}};
        vecs[10] = '{mk(1,0,0,F_BLT, 1, 2, 32'h100, 32'h20, 1, 32'h124),              '{1, 32'h120, 32'h104, 1}};
        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

        // ---------------- stall with ready_i low, then back-to-back -------
        xa = mk(1,0,0,F_BEQ, 5, 5, 32'h200, 32'h10, 1, 32'h210);
        xb = mk(1,0,0,F_BNE, 1, 2, 32'h300, 32'h8, 1, 32'h308);
        xc = mk(0,1,0,F_BEQ, 0, 0, 32'h400, 32'h4, 1, 32'h404);
        @(posedge clk); #1;
        drive(xa); bus.valid_i = 1'b1; bus.ready_i = 1'b0;
        @(posedge clk); #1;
        drive(xb);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stall_valid",  bus.valid_o, 1);
            chk("stall_target", bus.target_o, 32'h210);
            chk("stall_ready",  bus.ready_o, 0);
            $display("stall cycle %0d: valid=%0b target=0x%08h ready=%0b", c, bus.valid_o, bus.target_o, bus.ready_o);
            @(posedge clk); #1;
        end
        bus.ready_i = 1'b1;
        @(negedge clk);
        chk("b2b_ready", bus.ready_o, 1);
        @(posedge clk); #1;
        drive(xc);
        @(negedge clk);
        chk_res("b2b_x2", ref_model(xb));
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        @(negedge clk);
        chk_res("b2b_x3", ref_model(xc));
        @(posedge clk); #1;
        @(negedge clk);
        chk("b2b_drain", bus.valid_o, 0);

        // ---------------- flush in REDIR with ack and valid_i -------------
        @(posedge clk); #1;
        drive(vecs[1].in); bus.valid_i = 1'b1; bus.ready_i = 1'b0;
        @(posedge clk); #1;
        drive(vecs[3].in);
        @(negedge clk);
        chk("fl_pre_rv",    bus.redirect_valid_o, 1);
        chk("fl_pre_ready", bus.ready_o, 0);
        @(posedge clk); #1;
        bus.flush_i = 1'b1; bus.redirect_ack_i = 1'b1;
        @(posedge clk); #1;
        bus.flush_i = 1'b0; bus.redirect_ack_i = 1'b0; bus.valid_i = 1'b0; bus.ready_i = 1'b1;
        @(negedge clk);
        chk("fl_valid", bus.valid_o, 0);
        chk("fl_rv",    bus.redirect_valid_o, 0);
        chk("fl_ready", bus.ready_o, 1);
        $display("flush: valid=%0b redirect_valid=%0b ready=%0b", bus.valid_o, bus.redirect_valid_o, bus.ready_o);
        @(posedge clk); #1;
        @(negedge clk);
        chk("fl_dropped", bus.valid_o, 0);

        // ---------------- asynchronous reset while in REDIR ---------------
        @(posedge clk); #1;
        drive(vecs[2].in); bus.valid_i = 1'b1; bus.ready_i = 1'b0;
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rv",     bus.redirect_valid_o, 0);
        chk("arst_valid",  bus.valid_o, 0);
        chk("arst_rpc",    bus.redirect_pc_o, 0);
        chk("arst_target", bus.target_o, 0);
        chk("arst_ready",  bus.ready_o, 1);
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();

        // ---------------- XLEN=8: wrap and counter saturation -------------
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            bus8.is_br_i = 1'b1; bus8.funct3_i = F_BEQ;
            bus8.rs1_data_i = 8'd1; bus8.rs2_data_i = 8'd2;
            bus8.pc_i = 8'hFC; bus8.imm_i = 8'h10;
            bus8.pred_taken_i = 1'b1; bus8.pred_target_i = 8'h0C;
            bus8.valid_i = 1'b1; bus8.ready_i = 1'b1; bus8.redirect_ack_i = 1'b0;
            @(posedge clk); #1;
            bus8.valid_i = 1'b0;
            @(negedge clk);
            chk("x8_valid",  bus8.valid_o, 1);
            chk("x8_taken",  bus8.taken_o, 0);
            chk("x8_target", bus8.target_o, 8'h00);
            chk("x8_link",   bus8.link_o, 8'h00);
            chk("x8_mis",    bus8.mispredict_o, 1);
            @(posedge clk); #1;
            bus8.redirect_ack_i = 1'b1;
            @(negedge clk);
            chk("x8_miscnt", bus8.mispred_cnt_o, PERF ? ((k > 3) ? 3 : k) : 0);
            chk("x8_brcnt",  bus8.br_cnt_o,      PERF ? ((k > 3) ? 3 : k) : 0);
            $display("x8 iter %0d: target=0x%02h mispred_cnt=%0d", k, bus8.target_o, bus8.mispred_cnt_o);
            @(posedge clk); #1;
            bus8.redirect_ack_i = 1'b0;
        end

        // ---------------- randomized phase against the model --------------
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_valid = 1'b0; m_redir = 1'b0; m_rpc = '0; m_br = 0; m_mis = 0;
        m_res = '{0, 0, 0, 0};
        for (int cyc = 0; cyc < 400; cyc++) begin
            int kind;
            @(posedge clk); #1;
            kind = $urandom_range(0, 5);
            rx.br = (kind <= 2); rx.unc = (kind == 3); rx.jalr = (kind == 4);
            rx.f3 = 3'($urandom_range(0, 7));
            rx.rs1 = $urandom;
            rx.rs2 = ($urandom_range(0, 3) == 0) ? rx.rs1 : $urandom;
            rx.pc = $urandom & 32'hFFFF_FFFC;
            rx.imm = $urandom_range(0, 1) ? 32'($urandom_range(0, 4095)) : $urandom;
            rx.pt = 1'($urandom_range(0, 1));
            rx.ptgt = 32'h0;
            e = ref_model(rx);
            rx.ptgt = $urandom_range(0, 1) ? e.target : $urandom;
            r_vld = ($urandom_range(0, 9) < 7);
            r_rdy = ($urandom_range(0, 9) < 6);
            r_ack = ($urandom_range(0, 9) < 3);
            r_fl  = ($urandom_range(0, 19) == 0);
            drive(rx);
            bus.valid_i = r_vld; bus.ready_i = r_rdy; bus.redirect_ack_i = r_ack; bus.flush_i = r_fl;
            @(negedge clk);
            m_ready = !m_redir && (!m_valid || r_rdy);
            chk($sformatf("rnd%0d_valid", cyc), bus.valid_o, m_valid);
            chk($sformatf("rnd%0d_ready", cyc), bus.ready_o, m_ready);
            chk($sformatf("rnd%0d_rv", cyc),    bus.redirect_valid_o, m_redir);
            if (m_valid) chk_res($sformatf("rnd%0d", cyc), m_res);
            if (m_redir) chk($sformatf("rnd%0d_rpc", cyc), bus.redirect_pc_o, m_rpc);
            chk($sformatf("rnd%0d_brcnt", cyc),  bus.br_cnt_o,      PERF ? 64'(m_br)  : 0);
            chk($sformatf("rnd%0d_miscnt", cyc), bus.mispred_cnt_o, PERF ? 64'(m_mis) : 0);
            // advance model across the coming edge
            if (r_fl) begin
                m_valid = 1'b0; m_redir = 1'b0;
            end else begin
                if (m_valid && r_rdy) begin
                    if (m_br < 64'hFFFF_FFFF) m_br++;
                    if (m_res.mis && m_mis < 64'hFFFF_FFFF) m_mis++;
                end
                if (m_redir && r_ack) m_redir = 1'b0;
                if (r_vld && m_ready) begin
                    m_valid = 1'b1;
                    m_res = ref_model(rx);
                    if (m_res.mis) begin
                        m_redir = 1'b1;
                        m_rpc = m_res.target;
                    end
                end else if (m_valid && r_rdy) begin
                    m_valid = 1'b0;
                end
            end
        end
        $display("random phase: %0d retired, %0d mispredicted (model)", m_br, m_mis);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
